// File: rtl/ascon_pkg.sv
// Shared Ascon types, plus the tables and helpers used by the inverse permutation.
// Linear-layer inverse matrices are derived at elaboration by GF(2) elimination.
package ascon_pkg;

    localparam int NUM_WORDS  = 5;
    localparam int WORD_WIDTH = 64;

    typedef logic [WORD_WIDTH-1:0] ascon_word_t;
    typedef logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] ascon_state_t;
    typedef logic [WORD_WIDTH-1:0][WORD_WIDTH-1:0] lin_mat_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} inv_state_e;

    localparam logic [4:0] INV_SBOX [0:31] = '{
        5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
        5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
        5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
        5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
    };

    localparam logic [7:0] RC [0:11] = '{
        8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
    };

    localparam int ROT_AMT [0:NUM_WORDS-1][0:1] = '{
        '{19, 28}, '{61, 39}, '{1, 6}, '{10, 17}, '{7, 41}
    };

    // Row r of the result holds the input-bit mask feeding output bit r.
    function automatic lin_mat_t linv_matrix(input int w);
        lin_mat_t    a;
        lin_mat_t    inv;
        ascon_word_t tmp;
        logic        found;
        for (int r = 0; r < WORD_WIDTH; r++) begin
            a[r] = (ascon_word_t'(1) << r)
                 ^ (ascon_word_t'(1) << ((r + ROT_AMT[w][0]) % WORD_WIDTH))
                 ^ (ascon_word_t'(1) << ((r + ROT_AMT[w][1]) % WORD_WIDTH));
            inv[r] = ascon_word_t'(1) << r;
        end
        for (int c = 0; c < WORD_WIDTH; c++) begin
            found = 1'b0;
            for (int r = c; r < WORD_WIDTH; r++) begin
                if (!found && a[r][c]) begin
                    found  = 1'b1;
                    tmp    = a[r];
                    a[r]   = a[c];
                    a[c]   = tmp;
                    tmp    = inv[r];
                    inv[r] = inv[c];
                    inv[c] = tmp;
                end
            end
            for (int r = 0; r < WORD_WIDTH; r++) begin
                if (r != c && a[r][c]) begin
                    a[r]   = a[r] ^ a[c];
                    inv[r] = inv[r] ^ inv[c];
                end
            end
        end
        return inv;
    endfunction

    function automatic ascon_word_t mat_apply(input lin_mat_t m, input ascon_word_t x);
        ascon_word_t y;
        for (int r = 0; r < WORD_WIDTH; r++) begin
            y[r] = ^(m[r] & x);
        end
        return y;
    endfunction

    // Indices past the table yield zero so a wrapped counter is harmless.
    function automatic logic [7:0] rc_lookup(input logic [3:0] idx);
        logic [7:0] v;
        v = 8'h00;
        for (int k = 0; k < 12; k++) begin
            if (idx == 4'(k)) v = RC[k];
        end
        return v;
    endfunction

endpackage

// File: rtl/ascon_inv_permutation_inv_substitution_layer.sv
// Bit-sliced inverse Ascon S-box applied to all 64 columns of the state.
// Column index is {x0,x1,x2,x3,x4} with x0 as the MSB.
module inv_substitution_layer
    import ascon_pkg::*;
(
    input  ascon_state_t state,
    output ascon_state_t subst
);

    logic [4:0] idx;
    logic [4:0] val;

    always_comb begin
        subst = '0;
        idx   = '0;
        val   = '0;
        for (int j = 0; j < WORD_WIDTH; j++) begin
            idx = {state[0][j], state[1][j], state[2][j], state[3][j], state[4][j]};
            val = INV_SBOX[idx];
            subst[0][j] = val[4];
            subst[1][j] = val[3];
            subst[2][j] = val[2];
            subst[3][j] = val[1];
            subst[4][j] = val[0];
        end
    end

endmodule

// File: rtl/ascon_inv_permutation.sv
// Iterative inverse Ascon permutation, one inverse round per cycle.
// Define ASCON_INV_UNROLL2_EN to retire two inverse rounds per cycle.
module ascon_inv_permutation
    import ascon_pkg::*;
#(
    parameter int MAX_ROUNDS = 12
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [3:0]   rounds_i,
    input  ascon_state_t state_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output ascon_state_t state_o,
    output logic         busy_o
);

    localparam logic [3:0] MAX_RND = 4'(MAX_ROUNDS);
    localparam logic [3:0] LAST_RC = 4'(MAX_ROUNDS - 1);

    inv_state_e   fsm_q, fsm_d;
    ascon_state_t state_q, state_d;
    logic [3:0]   rc_idx_q, rc_idx_d;
    logic [3:0]   remain_q, remain_d;
    logic [3:0]   rnd_sat;

    ascon_state_t lin1, sub1, rnd1;
`ifdef ASCON_INV_UNROLL2_EN
    ascon_state_t lin2, sub2, rnd2;
`endif

    for (genvar w = 0; w < NUM_WORDS; w++) begin : g_lin
        localparam lin_mat_t LINV = linv_matrix(w);
        assign lin1[w] = mat_apply(LINV, state_q[w]);
`ifdef ASCON_INV_UNROLL2_EN
        assign lin2[w] = mat_apply(LINV, rnd1[w]);
`endif
    end

    inv_substitution_layer u_sub1 (
        .state (lin1),
        .subst (sub1)
    );

    always_comb begin
        rnd1    = sub1;
        rnd1[2] = sub1[2] ^ ascon_word_t'(rc_lookup(rc_idx_q));
    end

`ifdef ASCON_INV_UNROLL2_EN
    inv_substitution_layer u_sub2 (
        .state (lin2),
        .subst (sub2)
    );

    always_comb begin
        rnd2    = sub2;
        rnd2[2] = sub2[2] ^ ascon_word_t'(rc_lookup(rc_idx_q - 4'd1));
    end
`endif

    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        rc_idx_d = rc_idx_q;
        remain_d = remain_q;
        rnd_sat  = (rounds_i > MAX_RND) ? MAX_RND : rounds_i;
        unique case (fsm_q)
            IDLE: begin
                if (in_valid_i) begin
                    state_d  = state_i;
                    rc_idx_d = LAST_RC;
                    remain_d = rnd_sat;
                    fsm_d    = (rnd_sat == 4'd0) ? DONE : RUN;
                end
            end
            RUN: begin
`ifdef ASCON_INV_UNROLL2_EN
                if (remain_q >= 4'd2) begin
                    state_d  = rnd2;
                    rc_idx_d = rc_idx_q - 4'd2;
                    remain_d = remain_q - 4'd2;
                end else begin
                    state_d  = rnd1;
                    rc_idx_d = rc_idx_q - 4'd1;
                    remain_d = remain_q - 4'd1;
                end
                if (remain_q <= 4'd2) fsm_d = DONE;
`else
                state_d  = rnd1;
                rc_idx_d = rc_idx_q - 4'd1;
                remain_d = remain_q - 4'd1;
                if (remain_q == 4'd1) fsm_d = DONE;
`endif
            end
            DONE: begin
                if (out_ready_i) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fsm_q    <= IDLE;
            state_q  <= '0;
            rc_idx_q <= '0;
            remain_q <= '0;
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            rc_idx_q <= rc_idx_d;
            remain_q <= remain_d;
        end
    end

    assign in_ready_o  = (fsm_q == IDLE);
    assign out_valid_o = (fsm_q == DONE);
    assign busy_o      = (fsm_q != IDLE);
    assign state_o     = state_q;

endmodule
